// File: rtl/qreg_serial_out.sv
// qreg_serial_out
// Output stage beside the register file. Every write to Q is queued in a
// small circular FIFO. The queue is drained as an asynchronous serial frame
// on tx: idle high, start bit, 8 data bits LSB first, optional parity, stop.
// Build option: define QOUT_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit. Without it, no parity logic exists.
module qreg_serial_out #(
  parameter int DEPTH      = 4,  // FIFO entries, power of two, >= 2
  parameter int BIT_CYCLES = 4   // clk cycles per serial bit, >= 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       loadQ,
  input  logic [7:0]                 qreg,
  output logic                       tx,
  output logic                       busy,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);
  localparam int TimW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TimW-1:0] LastTick = TimW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef QOUT_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } txStateT;

  txStateT         state;
  logic            loadQd;
  logic [7:0]      fifoMem [DEPTH];
  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [7:0]      shifter;
  logic [2:0]      bitIdx;
  logic [TimW-1:0] bitTimer;
  logic            push;
  logic            pop;
  logic            lastTick;
`ifdef QOUT_PARITY_EN
  logic            parityBit;
`endif

  // IDLE takes the head whenever something is queued. A pop on the same edge
  // frees a slot, so a push into a full FIFO still succeeds then.
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign full     = (fifo_count == DepthCnt);
  assign push     = loadQd && (!full || pop);
  assign lastTick = (bitTimer == LastTick);

  // Delay the Q-load strobe one cycle, so qreg already holds the new value at the push.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments in every clocked block, so all registers see pre-edge values.
    if (reset) loadQd <= 1'b0;
    else       loadQd <= loadQ;
  end

  // FIFO storage: write the captured byte at the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset. Reset clears the pointers and count, so no stale entry is ever read back.
    if (push) fifoMem[wrPtr] <= qreg;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (loadQd && !push) overflow <= 1'b1;
    end
  end

  // Frame sequencer: tx and busy are registered here with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      shifter   <= '0;
      bitIdx    <= '0;
      bitTimer  <= '0;
`ifdef QOUT_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          bitTimer <= '0;
          if (pop) begin
            shifter   <= fifoMem[rdPtr];
`ifdef QOUT_PARITY_EN
            parityBit <= ^fifoMem[rdPtr];
`endif
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (lastTick) begin
            bitTimer <= '0;
            bitIdx   <= '0;
            tx       <= shifter[0];
            state    <= DATA;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        DATA: begin
          if (lastTick) begin
            bitTimer <= '0;
            if (bitIdx == 3'd7) begin
`ifdef QOUT_PARITY_EN
              tx    <= parityBit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // Bit 0 of shifter is on the line now. Put the next bit out and advance.
              tx      <= shifter[1];
              shifter <= shifter >> 1;
              bitIdx  <= bitIdx + 1'b1;
            end
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
`ifdef QOUT_PARITY_EN
        PARITY: begin
          if (lastTick) begin
            bitTimer <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (lastTick) begin
            bitTimer <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            bitTimer <= bitTimer + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          bitTimer <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qreg_serial_out.sv
// tb_qreg_serial_out
// Directed bench for qreg_serial_out. Instance A uses BIT_CYCLES=4 and has a
// frame decoder watching its tx. Instance B uses BIT_CYCLES=1 and checks the
// one-clock-per-bit case. Expected frames carry a parity bit when
// QOUT_PARITY_EN is defined.
module tb_qreg_serial_out;

  localparam int DEPTH = 4;
  localparam int BC0   = 4;
  localparam int BC1   = 1;
`ifdef QOUT_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       loadQA, loadQB;
  logic [7:0] qregA, qregB;
  logic       txA, busyA, fullA, ovfA;
  logic       txB, busyB, fullB, ovfB;
  logic [2:0] cntA, cntB;

  always #5 clk = ~clk;

  qreg_serial_out #(.DEPTH(DEPTH), .BIT_CYCLES(BC0)) dutA (
    .clk(clk), .reset(reset), .loadQ(loadQA), .qreg(qregA),
    .tx(txA), .busy(busyA), .full(fullA), .fifo_count(cntA), .overflow(ovfA)
  );

  qreg_serial_out #(.DEPTH(DEPTH), .BIT_CYCLES(BC1)) dutB (
    .clk(clk), .reset(reset), .loadQ(loadQB), .qreg(qregB),
    .tx(txB), .busy(busyB), .full(fullB), .fifo_count(cntB), .overflow(ovfB)
  );

  int nTests = 0;
  int nFail  = 0;
  logic [7:0] burstVals [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for each bit slot of one frame.
  function automatic logic [10:0] frameBits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef QOUT_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Q written on n consecutive edges. qreg changes just after each edge, like the real Q register.
  task automatic writeBurst(input bit sel, input int n);
    if (sel) loadQB = 1'b1; else loadQA = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sel) qregB = burstVals[i]; else qregA = burstVals[i];
      if (i == n - 1) begin
        if (sel) loadQB = 1'b0; else loadQA = 1'b0;
      end
    end
  endtask

  // Called just after write edge E on an idle DUT. Checks tx every cycle from E+2 to the end of the frame.
  task automatic checkFrame(input bit sel, input logic [7:0] b, input string tag);
    logic [10:0] fb;
    int bc;
    fb = frameBits(b);
    bc = sel ? BC1 : BC0;
    tick();
    tick();
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < bc; c++) begin
        check($sformatf("%s bit%0d cyc%0d tx", tag, i, c), sel ? txB : txA, fb[i]);
        if (c == 0) check($sformatf("%s bit%0d busy", tag, i), sel ? busyB : busyA, 1'b1);
        tick();
      end
    end
    check({tag, " busy fall"}, sel ? busyB : busyA, 1'b0);
    check({tag, " tx idle"}, sel ? txB : txA, 1'b1);
  endtask

  // Frame decoder on dutA. It samples at the falling edge, at the first cycle of each bit.
  logic [7:0] monQ [$];
  int         monBadStop = 0;
  bit         monActive  = 1'b0;
  int         monCnt     = 0;
  logic [7:0] monByte    = '0;

  always @(negedge clk) begin
    int nc, k;
    if (reset) begin
      monActive <= 1'b0;
    end else if (!monActive) begin
      if (txA === 1'b0) begin
        monActive <= 1'b1;
        monCnt    <= 0;
      end
    end else begin
      nc = monCnt + 1;
      monCnt <= nc;
      if (nc % BC0 == 0) begin
        k = nc / BC0;
        if (k >= 1 && k <= 8) begin
          monByte[k-1] <= txA;
        end else if (k == NBITS - 1) begin
          if (txA !== 1'b1) monBadStop <= monBadStop + 1;
          monQ.push_back(monByte);
          monActive <= 1'b0;
        end
      end
    end
  end

  // Wait until dutA has drained and the decoder holds want frames, within a cycle budget.
  task automatic waitDrain(input int want, input string tag);
    int cyc;
    cyc = 0;
    while (!(monQ.size() >= want && !busyA && cntA == 3'd0) && cyc < 800) begin
      tick();
      cyc++;
    end
    check({tag, " drained in time"}, (cyc < 800) ? 1'b1 : 1'b0, 1'b1);
    check({tag, " frame count"}, monQ.size(), want);
  endtask

  initial begin
    int lows;
    reset  = 1'b1;
    loadQA = 1'b0; loadQB = 1'b0;
    qregA  = 8'h00; qregB = 8'h00;
    tick(); tick(); tick();
    reset = 1'b0;
    tick(); tick();

    // 1: reset state, then reset asserted while idle and held for 3 clocks
    check("rst tx", txA, 1'b1);
    check("rst busy", busyA, 1'b0);
    check("rst count", cntA, 3'd0);
    check("rst overflow", ovfA, 1'b0);
    check("rst full", fullA, 1'b0);
    reset = 1'b1;
    #1;
    check("idle rst tx", txA, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d tx", i), txA, 1'b1);
      check($sformatf("hold%0d busy", i), busyA, 1'b0);
      check($sformatf("hold%0d count", i), cntA, 3'd0);
      check($sformatf("hold%0d overflow", i), ovfA, 1'b0);
    end
    reset = 1'b0;
    tick();

    // 2: single write of 0xA5, exact cycle timing
    burstVals[0] = 8'hA5;
    writeBurst(1'b0, 1);
    checkFrame(1'b0, 8'hA5, "A5");
    tick(); tick();
    check("A5 decoded", monQ.size(), 1);
    if (monQ.size() > 0) check("A5 byte", monQ[0], 8'hA5);
    monQ.delete();

    // 3: six writes back to back. One is sent, four are queued, the sixth is dropped.
    burstVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    writeBurst(1'b0, 6);
    check("burst full before drop", fullA, 1'b1);
    check("burst ovf before drop", ovfA, 1'b0);
    tick();
    check("burst full", fullA, 1'b1);
    check("burst count", cntA, 3'd4);
    check("burst overflow", ovfA, 1'b1);
    waitDrain(5, "burst");
    for (int i = 0; i < 5 && i < monQ.size(); i++)
      check($sformatf("burst frame%0d", i), monQ[i], burstVals[i]);
    check("burst overflow sticky", ovfA, 1'b1);
    check("burst stop bits", monBadStop, 0);
    monQ.delete();

    // 4: push into a full FIFO on the same edge that IDLE pops
    reset = 1'b1;
    #1;
    check("ovf cleared by reset", ovfA, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    burstVals = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    writeBurst(1'b0, 5);
    for (int i = 0; i < 37; i++) tick();
    loadQA = 1'b1;
    tick();
    qregA  = burstVals[5];
    loadQA = 1'b0;
    check("samedge idle", busyA, 1'b0);
    check("samedge full", fullA, 1'b1);
    check("samedge count before", cntA, 3'd4);
    tick();
    check("samedge count after", cntA, 3'd4);
    check("samedge no overflow", ovfA, 1'b0);
    check("samedge busy", busyA, 1'b1);
    waitDrain(6, "samedge");
    for (int i = 0; i < 6 && i < monQ.size(); i++)
      check($sformatf("samedge frame%0d", i), monQ[i], burstVals[i]);
    check("samedge overflow end", ovfA, 1'b0);
    monQ.delete();

    // 5: reset during DATA bit 3 with two bytes queued
    burstVals[0] = 8'hF7; burstVals[1] = 8'h5A; burstVals[2] = 8'h3C;
    writeBurst(1'b0, 3);
    for (int i = 0; i < 17; i++) tick();
    check("midframe count", cntA, 3'd2);
    check("midframe bit3", txA, 1'b0);
    reset = 1'b1;
    #1;
    check("midframe rst tx", txA, 1'b1);
    check("midframe rst count", cntA, 3'd0);
    check("midframe rst busy", busyA, 1'b0);
    tick(); tick();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (txA !== 1'b1) lows++;
    end
    check("midframe no resume", lows, 0);
    check("midframe no frames", monQ.size(), 0);
    check("midframe busy", busyA, 1'b0);

    // 6: parity-sensitive bytes, at 4 clk/bit and at 1 clk/bit
    burstVals[0] = 8'h07;
    writeBurst(1'b0, 1);
    checkFrame(1'b0, 8'h07, "07 bc4");
    burstVals[0] = 8'h03;
    writeBurst(1'b0, 1);
    checkFrame(1'b0, 8'h03, "03 bc4");
    burstVals[0] = 8'h07;
    writeBurst(1'b1, 1);
    checkFrame(1'b1, 8'h07, "07 bc1");
    burstVals[0] = 8'h03;
    writeBurst(1'b1, 1);
    checkFrame(1'b1, 8'h03, "03 bc1");
    burstVals[0] = 8'hA5;
    writeBurst(1'b1, 1);
    checkFrame(1'b1, 8'hA5, "A5 bc1");
    check("bc1 overflow", ovfB, 1'b0);
    check("bc1 count", cntB, 3'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
